mux_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 2:1 mux datapath.
- Two requesters each present data and a request; the block grants one at a time and drives the mux select.
- Each accepted beat is registered onto a single output with a valid strobe.
- Bursts are capped so that neither requester can starve the other.

---
 rtl/mux_arbiter_pkg.sv | 22 ++
 rtl/mux_arbiter_if.sv | 29 ++
 rtl/mux_arbiter_mux.sv | 11 +
 rtl/mux_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  // Arbiter FSM encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G1   = 2'b01,
    G2   = 2'b10
  } state_t;

  // Requester identity, stored in the last-granted pointer.
  typedef logic req_id_t;

  localparam req_id_t REQ1 = 1'b0;
  localparam req_id_t REQ2 = 1'b1;

  // Burst counter width: enough to hold MAX_BURST-1, never narrower than 1.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Bundle of requester, downstream and result signals around the arbiter.
interface mux_arbiter_if #(
  parameter int WIDTH = 1
);

  logic             req1;
  logic             req2;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             ready;
  logic             gnt1;
  logic             gnt2;
  logic             s;
  logic [WIDTH-1:0] y;
  logic             valid;

  // Requesters and downstream sink drive requests, data and ready.
  modport master (
    output req1, req2, x1, x2, ready,
    input  gnt1, gnt2, s, y, valid
  );

  // The arbiter consumes requests and drives grants, select and output beat.
  modport slave (
    input  req1, req2, x1, x2, ready,
    output gnt1, gnt2, s, y, valid
  );

endinterface

// File: rtl/mux_arbiter_mux.sv
// Existing 1-bit 2:1 mux cell: s=0 passes x1, s=1 passes x2.
module Mux (
  output logic y,
  input  logic s,
  input  logic x1,
  input  logic x2
);

  assign y = s ? x2 : x1;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter and sequencer for the shared 2:1 mux datapath.
// Grants one requester at a time, caps bursts at MAX_BURST beats while the
// other requester waits, and registers each accepted beat onto y/valid.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  req_id_t          last;
  req_id_t          last_next;

  logic             gnt1_c;
  logic             gnt2_c;
  logic             sel;
  logic             beat;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_q;
  logic             valid_q;

  // A beat needs the current owner still requesting and the sink ready.
  assign beat = bus.ready &
                (((state == G1) & bus.req1) | ((state == G2) & bus.req2));

  // Datapath: one mux cell per data bit, all steered by the common select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    Mux u_mux (
      .y  (mux_y[i]),
      .s  (sel),
      .x1 (bus.x1[i]),
      .x2 (bus.x2[i])
    );
  end

  // State, burst counter and last-granted pointer; reset overrides everything.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= REQ2;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
    end
  end

  // Next-state, counter and pointer logic in rule-priority order.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    last_next  = last;
    case (state)
      IDLE: begin
        if (bus.req1 && (!bus.req2 || last == REQ2)) begin
          state_next = G1;
          last_next  = REQ1;
          cnt_next   = '0;
        end else if (bus.req2) begin
          state_next = G2;
          last_next  = REQ2;
          cnt_next   = '0;
        end
      end
      G1: begin
        if (!bus.req1) begin
          cnt_next = '0;
          if (bus.req2) begin
            state_next = G2;
            last_next  = REQ2;
          end else begin
            state_next = IDLE;
          end
        end else if (beat) begin
          if (cnt == CNT_LAST) begin
            // Burst limit: hand over if the other side waits, else restart.
            cnt_next = '0;
            if (bus.req2) begin
              state_next = G2;
              last_next  = REQ2;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      G2: begin
        if (!bus.req2) begin
          cnt_next = '0;
          if (bus.req1) begin
            state_next = G1;
            last_next  = REQ1;
          end else begin
            state_next = IDLE;
          end
        end else if (beat) begin
          if (cnt == CNT_LAST) begin
            cnt_next = '0;
            if (bus.req1) begin
              state_next = G1;
              last_next  = REQ1;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Grant and select decode straight from the state register.
  always_comb begin
    gnt1_c = 1'b0;
    gnt2_c = 1'b0;
    sel    = 1'b0;
    case (state)
      G1:      gnt1_c = 1'b1;
      G2: begin
        gnt2_c = 1'b1;
        sel    = 1'b1;
      end
      default: ;
    endcase
  end

  // Output beat register: capture mux data on a beat, otherwise hold y.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= beat;
      if (beat) begin
        y_q <= mux_y;
      end
    end
  end

  assign bus.gnt1  = gnt1_c;
  assign bus.gnt2  = gnt2_c;
  assign bus.s     = sel;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule
